// File: rtl/mont_reduce.sv
// Montgomery reduction of a signed 2*WIDTH product: out = a * 2^-WIDTH mod Q, normalised to [0, Q).
// Latency: 3 cycles from acceptance to out_valid (S1 t, S2 subtract, S3 normalise); 1 result/cycle.
// Backpressure: one global advance; out_valid && !out_ready freezes every stage and drops in_ready.
module mont_reduce #(
  parameter int WIDTH = 16,
  parameter int Q     = 3329,
  parameter int QINV  = 62209,
  parameter int OUT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               range_err
);

  localparam int PW = 2 * WIDTH;

  // QINV is Q^-1 mod 2^WIDTH, so a - t*Q clears the low WIDTH bits of the product.
  localparam logic [WIDTH-1:0]      QINV_W = WIDTH'(QINV);
  localparam logic signed [PW-1:0]  Q_P    = PW'(Q);
  localparam logic [OUT_W-1:0]      Q_O    = OUT_W'(Q);

  // Legal magnitude bound |a| < Q * 2^(WIDTH-1) keeps r = u >> WIDTH inside (-Q, Q).
  localparam logic signed [PW-1:0]  LIM    = PW'(Q * (2 ** (WIDTH - 1)));
  localparam logic signed [PW-1:0]  NLIM   = -LIM;

  // Single advance for the whole pipe: S3 empty or being drained.
  logic adv;
  logic accept;

  // Stage registers
  logic                    v1, v2, v3;
  logic signed [PW-1:0]    s1_a;
  logic signed [WIDTH-1:0] s1_t;
  logic signed [WIDTH-1:0] s2_r;
  logic [OUT_W-1:0]        s3_dat;

  // Next-stage values
  logic [WIDTH-1:0]        t_nxt;
  logic signed [PW-1:0]    t_ext;
  logic signed [PW-1:0]    u_nxt;
  logic [OUT_W-1:0]        r_lo;
  logic [OUT_W-1:0]        res_nxt;
  logic signed [PW-1:0]    a_s;
  logic                    oor;

  // Low bits of u are zero by construction; upper sign-extension bits of r are redundant.
  logic unused_bits;

  assign adv       = ~v3 | out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid & adv;
  assign out_valid = v3;
  assign out_data  = s3_dat;

  // Datapath arithmetic for each stage boundary and the input range check.
  always_comb begin
    t_nxt   = '0;
    t_ext   = '0;
    u_nxt   = '0;
    r_lo    = '0;
    res_nxt = '0;
    a_s     = '0;
    oor     = 1'b0;

    // t = low WIDTH bits of a * QINV, read later as signed.
    t_nxt   = in_data[WIDTH-1:0] * QINV_W;

    // u = a - t*Q in full-width signed arithmetic.
    t_ext   = {{WIDTH{s1_t[WIDTH-1]}}, s1_t};
    u_nxt   = s1_a - (t_ext * Q_P);

    // r in (-Q, Q): fold negatives by adding Q; modulo 2^OUT_W arithmetic is exact here.
    r_lo    = s2_r[OUT_W-1:0];
    res_nxt = s2_r[WIDTH-1] ? (r_lo + Q_O) : r_lo;

    a_s     = $signed(in_data);
    oor     = (a_s >= LIM) || (a_s <= NLIM);
  end

  assign unused_bits = ^{u_nxt[WIDTH-1:0], s2_r[WIDTH-2:OUT_W]};

  // Pipeline registers: everything moves together on adv, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_a   <= '0;
      s1_t   <= '0;
      s2_r   <= '0;
      s3_dat <= '0;
    end else if (adv) begin
      v1     <= accept;
      s1_a   <= a_s;
      s1_t   <= t_nxt;
      v2     <= v1;
      s2_r   <= u_nxt[PW-1:WIDTH];
      v3     <= v2;
      s3_dat <= res_nxt;
    end
  end

  // Sticky out-of-range flag; the offending item still flows through.
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (accept && oor) begin
      range_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mont_reduce.sv
module tb_mont_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        range_err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic acc;
  logic fire;
  int   exp_q[$];
  int   acy_q[$];

  mont_reduce #(.WIDTH(16), .Q(3329), .QINV(62209), .OUT_W(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  // Reference: a * R^-1 mod Q with R^-1 = 169 (65536 * 169 = 1 mod 3329).
  function automatic int ref_red(input longint a);
    longint m;
    m = a % 3329;
    if (m < 0) m = m + 3329;
    return int'((m * 169) % 3329);
  endfunction

  // Drive one cycle's inputs at negedge and sample DUT 1ns later, well before the next posedge.
  task automatic step(input logic v, input int d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    cyc++;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    acy_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 12'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL reset_range_err got=%b exp=0", range_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known();
    int kv_a[6];
    int kv_e[6];
    int i;
    int n_out;
    int d;
    kv_a = '{0, 1, 65536, -65536, 3329, 149749760};
    kv_e = '{0, 169, 1, 3328, 0, 2285};
    i = 0; n_out = 0;
    for (int c = 0; c < 40 && n_out < 6; c++) begin
      d = (i < 6) ? kv_a[i] : 0;
      step(i < 6, d, 1'b1);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL known_spurious got=%0d exp=none", out_data);
        end else begin
          if (out_data !== 12'(exp_q[0]) || cyc !== acy_q[0] + 3) begin
            failures++;
            $display("FAIL known_value idx=%0d got=%0d@%0d exp=%0d@%0d", n_out, out_data, cyc, exp_q[0], acy_q[0] + 3);
          end
          void'(exp_q.pop_front()); void'(acy_q.pop_front());
        end
        n_out++;
      end
      if (acc) begin exp_q.push_back(kv_e[i]); acy_q.push_back(cyc); i++; end
    end
    checks++; if (n_out !== 6) begin failures++; $display("FAIL known_count got=%0d exp=6", n_out); end
  endtask

  task automatic test_bounds();
    int vals[23];
    int idx;
    int n_out;
    logic err_exp;
    pulse_rst();
    vals[0] = 109084671;
    vals[1] = -109084671;
    vals[2] = 109084672;
    for (int j = 0; j < 20; j++) vals[3 + j] = j * 4001 - 30000;
    idx = 0; n_out = 0; err_exp = 1'b0;
    for (int c = 0; c < 100 && n_out < 23; c++) begin
      step(idx < 23, (idx < 23) ? vals[idx] : 0, 1'b1);
      checks++;
      if (range_err !== err_exp) begin
        failures++; $display("FAIL bound_range_err cyc=%0d got=%b exp=%b", c, range_err, err_exp);
      end
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL bound_spurious got=%0d exp=none", out_data);
        end else begin
          if (exp_q[0] >= 0) begin
            checks++;
            if (out_data !== 12'(exp_q[0])) begin
              failures++; $display("FAIL bound_value idx=%0d got=%0d exp=%0d", n_out, out_data, exp_q[0]);
            end
          end
          void'(exp_q.pop_front());
        end
        n_out++;
      end
      if (acc) begin
        if (idx == 0)      exp_q.push_back(3160);
        else if (idx == 1) exp_q.push_back(169);
        else if (idx == 2) begin exp_q.push_back(-1); err_exp = 1'b1; end
        else               exp_q.push_back(ref_red(vals[idx]));
        idx++;
      end
    end
    checks++; if (n_out !== 23) begin failures++; $display("FAIL bound_count got=%0d exp=23", n_out); end
  endtask

  task automatic test_backpressure();
    int n_in;
    int n_out;
    int d;
    logic prev_stall;
    logic [11:0] prev_dat;
    n_in = 0; n_out = 0; prev_stall = 1'b0; prev_dat = '0;
    exp_q.delete();
    for (int c = 0; c < 200 && n_out < 10; c++) begin
      d = n_in * 10007 - 40000;
      step(n_in < 10, d, (c % 3) == 0);
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, !(out_valid && !out_ready));
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_dat) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/%0d", c, out_valid, out_data, prev_dat);
        end
      end
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_spurious got=%0d exp=none", out_data);
        end else begin
          if (out_data !== 12'(exp_q[0])) begin
            failures++; $display("FAIL bp_value idx=%0d got=%0d exp=%0d", n_out, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_out++;
      end
      if (acc) begin exp_q.push_back(ref_red(d)); n_in++; end
      prev_stall = out_valid && !out_ready;
      prev_dat   = out_data;
    end
    checks++;
    if (n_out !== 10 || exp_q.size() !== 0) begin
      failures++; $display("FAIL bp_count got=%0d exp=10 left=%0d", n_out, exp_q.size());
    end
  endtask

  task automatic test_bubble();
    logic vin[14];
    logic exp_v;
    for (int c = 0; c < 14; c++) begin
      vin[c] = (c < 8) && (c % 2 == 0);
      step(vin[c], c * 3 + 7, 1'b1);
      exp_v = (c >= 3) ? vin[c - 3] : 1'b0;
      checks++;
      if (out_valid !== exp_v) begin
        failures++; $display("FAIL bubble_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_v);
      end
    end
  endtask

  task automatic test_midflight();
    int n;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      step(1'b1, (n == 1) ? 120000000 : 5000 * n + 1, 1'b0);
      if (acc) n++;
    end
    step(1'b0, 0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || range_err !== 1'b1) begin
      failures++; $display("FAIL mid_full got=rdy%b/vld%b/err%b exp=rdy0/vld1/err1", in_ready, out_valid, range_err);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_after_rst got=vld%b/err%b/rdy%b exp=vld0/err0/rdy1", out_valid, range_err, in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 0, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_random();
    int a, b;
    longint p;
    int cur;
    int n_in;
    int n_out;
    logic pend_v;
    pulse_rst();
    n_in = 0; n_out = 0;
    cur = 0;
    for (int c = 0; c < 60000 && n_out < 10000; c++) begin
      if (n_in < 10000 && c == 0) begin
        do begin
          a = int'($urandom_range(0, 65535)) - 32768;
          b = int'($urandom_range(0, 65535)) - 32768;
          p = longint'(a) * longint'(b);
        end while (p >= 109084672 || p <= -109084672);
        cur = int'(p);
      end
      pend_v = (n_in < 10000) && ($urandom_range(0, 3) != 0);
      step(pend_v, cur, $urandom_range(0, 3) != 0);
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_spurious got=%0d exp=none", out_data);
        end else begin
          if (out_data !== 12'(exp_q[0])) begin
            failures++; $display("FAIL rand_value idx=%0d got=%0d exp=%0d", n_out, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        n_out++;
      end
      if (acc) begin
        exp_q.push_back(ref_red(longint'(cur)));
        n_in++;
        do begin
          a = int'($urandom_range(0, 65535)) - 32768;
          b = int'($urandom_range(0, 65535)) - 32768;
          p = longint'(a) * longint'(b);
        end while (p >= 109084672 || p <= -109084672);
        cur = int'(p);
      end
    end
    checks++; if (n_out !== 10000) begin failures++; $display("FAIL rand_count got=%0d exp=10000", n_out); end
    checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL rand_range_err got=%b exp=0", range_err); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_bounds();
    test_backpressure();
    test_bubble();
    test_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
